// File: rtl/bpred_pkg.sv
// bpred_pkg: shared definitions for the next-PC branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - default table geometry (IDX_BITS/TAG_BITS)
//   - PC index/tag extraction helpers
//   - saturating counter next-state helper
package bpred_pkg;

    localparam int unsigned IDX_BITS_DEF = 32'd6;
    localparam int unsigned TAG_BITS_DEF = 32'd8;

    // Direction counter encodings; bit 1 is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } ctr_e;

    // Extract a right-justified bit field of 'width' bits starting at 'lsb'.
    function automatic logic [31:0] pc_field(input logic [31:0] pc,
                                             input int unsigned lsb,
                                             input int unsigned width);
        logic [31:0] mask_v;
        if (width >= 32'd32) begin
            mask_v = 32'hFFFF_FFFF;
        end else begin
            mask_v = (32'd1 << width) - 32'd1;
        end
        return (pc >> lsb) & mask_v;
    endfunction

    // Table index: pc[idx_bits+1:2]; the two byte-offset bits are ignored.
    function automatic logic [31:0] pc_idx(input logic [31:0] pc,
                                           input int unsigned idx_bits);
        return pc_field(pc, 32'd2, idx_bits);
    endfunction

    // Partial tag: the tag_bits immediately above the index.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                           input int unsigned idx_bits,
                                           input int unsigned tag_bits);
        return pc_field(pc, idx_bits + 32'd2, tag_bits);
    endfunction

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                            input logic taken);
        logic [1:0] nxt_v;
        case (ctr)
            SNT:     nxt_v = taken ? WNT : SNT;
            WNT:     nxt_v = taken ? WT  : SNT;
            WT:      nxt_v = taken ? ST  : WNT;
            ST:      nxt_v = taken ? ST  : WT;
            default: nxt_v = ctr;
        endcase
        return nxt_v;
    endfunction

endpackage

// File: rtl/m_bpred_table.sv
// m_bpred_table: direct-mapped BTB storage.
//   Holds a valid vector (asynchronously cleared) and non-reset tag, target
//   and counter arrays.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (valid bits only)
//   rd_idx -> rd_*       combinational lookup read port
//   ur_idx -> ur_*       combinational read of the entry being trained, so the
//                        owner can make its read-modify-write decision
//   wr_en/wr_idx/wr_*    single write port; a write always marks the entry valid
module m_bpred_table
    import bpred_pkg::*;
#(
    parameter int unsigned IDX_BITS = IDX_BITS_DEF,
    parameter int unsigned TAG_BITS = TAG_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic                rd_valid,
    output logic [TAG_BITS-1:0] rd_tag,
    output logic [31:0]         rd_target,
    output logic [1:0]          rd_ctr,
    input  logic [IDX_BITS-1:0] ur_idx,
    output logic                ur_valid,
    output logic [TAG_BITS-1:0] ur_tag,
    output logic [31:0]         ur_target,
    output logic [1:0]          ur_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_target,
    input  logic [1:0]          wr_ctr
);

    localparam int unsigned ENTRIES = 32'd1 << IDX_BITS;

    logic [ENTRIES-1:0]  valid_r;
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    // Valid bits: the only table state that reset touches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= {ENTRIES{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Payload arrays: no reset, contents are qualified by valid_r.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
            ctr_r[wr_idx]    <= wr_ctr;
        end
    end

    assign rd_valid  = valid_r[rd_idx];
    assign rd_tag    = tag_r[rd_idx];
    assign rd_target = target_r[rd_idx];
    assign rd_ctr    = ctr_r[rd_idx];

    assign ur_valid  = valid_r[ur_idx];
    assign ur_tag    = tag_r[ur_idx];
    assign ur_target = target_r[ur_idx];
    assign ur_ctr    = ctr_r[ur_idx];

endmodule

// File: rtl/m_branch_predictor.sv
// m_branch_predictor: next-PC predictor in front of fetch. Direct-mapped BTB
// with a 2-bit saturating direction counter per entry. The prediction is
// registered so it lines up with the synchronous instruction-memory word for
// the same PC; training comes from the memory stage on branch resolution.
// Optional build macro: BPRED_BYPASS_EN -- a lookup that hits the index being
// written on the same edge sees the post-update entry instead of the old one.
// Ports:
//   clk, rst_n, ce                 clock, async active-low reset, clock enable
//   lookup_pc                      fetch PC this cycle
//   pred_hit/pred_taken/pred_target registered prediction for previous lookup_pc
//   upd_valid/upd_pc/upd_taken/upd_target  branch resolution training input
module m_branch_predictor
    import bpred_pkg::*;
#(
    parameter int unsigned IDX_BITS = IDX_BITS_DEF,
    parameter int unsigned TAG_BITS = TAG_BITS_DEF,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    logic [IDX_BITS-1:0] lk_idx_s;
    logic [TAG_BITS-1:0] lk_tag_s;
    logic [IDX_BITS-1:0] up_idx_s;
    logic [TAG_BITS-1:0] up_tag_s;

    logic                rd_valid_s;
    logic [TAG_BITS-1:0] rd_tag_s;
    logic [31:0]         rd_target_s;
    logic [1:0]          rd_ctr_s;

    logic                ur_valid_s;
    logic [TAG_BITS-1:0] ur_tag_s;
    logic [31:0]         ur_target_s;
    logic [1:0]          ur_ctr_s;

    logic                up_hit_s;
    logic                wr_en_s;
    logic [TAG_BITS-1:0] wr_tag_s;
    logic [31:0]         wr_target_s;
    logic [1:0]          wr_ctr_s;

    logic                view_valid_s;
    logic [TAG_BITS-1:0] view_tag_s;
    logic [31:0]         view_target_s;
    logic [1:0]          view_ctr_s;

    logic                hit_s;
    logic                taken_s;
    logic [31:0]         target_s;

    assign lk_idx_s = IDX_BITS'(pc_idx(lookup_pc, IDX_BITS));
    assign lk_tag_s = TAG_BITS'(pc_tag(lookup_pc, IDX_BITS, TAG_BITS));
    assign up_idx_s = IDX_BITS'(pc_idx(upd_pc, IDX_BITS));
    assign up_tag_s = TAG_BITS'(pc_tag(upd_pc, IDX_BITS, TAG_BITS));

    m_bpred_table #(
        .IDX_BITS (IDX_BITS),
        .TAG_BITS (TAG_BITS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (lk_idx_s),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_target (rd_target_s),
        .rd_ctr    (rd_ctr_s),
        .ur_idx    (up_idx_s),
        .ur_valid  (ur_valid_s),
        .ur_tag    (ur_tag_s),
        .ur_target (ur_target_s),
        .ur_ctr    (ur_ctr_s),
        .wr_en     (wr_en_s),
        .wr_idx    (up_idx_s),
        .wr_tag    (wr_tag_s),
        .wr_target (wr_target_s),
        .wr_ctr    (wr_ctr_s)
    );

    assign up_hit_s = ur_valid_s && (ur_tag_s == up_tag_s);

    // Training decision: train on hit, allocate on taken miss, ignore a
    // not-taken miss. A not-taken hit keeps the old target so a later
    // taken prediction still has a destination.
    always_comb begin
        wr_en_s     = 1'b0;
        wr_tag_s    = up_tag_s;
        wr_target_s = ur_target_s;
        wr_ctr_s    = ur_ctr_s;
        if (ce && upd_valid) begin
            if (up_hit_s) begin
                wr_en_s     = 1'b1;
                wr_ctr_s    = ctr_next(ur_ctr_s, upd_taken);
                wr_target_s = upd_taken ? upd_target : ur_target_s;
            end else if (upd_taken) begin
                wr_en_s     = 1'b1;
                wr_ctr_s    = CTR_INIT;
                wr_target_s = upd_target;
            end else begin
                wr_en_s     = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry seen by the lookup: stored entry, or the entry being written
    // this edge when same-index forwarding is built in.
    always_comb begin
        view_valid_s  = rd_valid_s;
        view_tag_s    = rd_tag_s;
        view_target_s = rd_target_s;
        view_ctr_s    = rd_ctr_s;
`ifdef BPRED_BYPASS_EN
        if (wr_en_s && (up_idx_s == lk_idx_s)) begin
            view_valid_s  = 1'b1;
            view_tag_s    = wr_tag_s;
            view_target_s = wr_target_s;
            view_ctr_s    = wr_ctr_s;
        end else begin
            view_valid_s  = rd_valid_s;
        end
`endif
    end

    // Prediction from the selected entry; fall-through is 32-bit modulo.
    always_comb begin
        hit_s   = view_valid_s && (view_tag_s == lk_tag_s);
        taken_s = hit_s && view_ctr_s[1];
        if (taken_s) begin
            target_s = view_target_s;
        end else begin
            target_s = lookup_pc + 32'd4;
        end
    end

    // Registered prediction outputs; frozen while ce is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= 32'd0;
        end else if (ce) begin
            pred_hit    <= hit_s;
            pred_taken  <= taken_s;
            pred_target <= target_s;
        end else begin
            pred_hit    <= pred_hit;
            pred_taken  <= pred_taken;
            pred_target <= pred_target;
        end
    end

endmodule

// File: tb/tb_m_branch_predictor.sv
// Self-checking bench for m_branch_predictor: a reference model of the BTB
// produces the expected prediction for each driven cycle, which is queued and
// compared against the DUT outputs one clock later.
module tb_m_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t sb_q[$];
    exp_t prev_exp;

    // Reference model state.
    bit          mv  [64];
    logic [7:0]  mt  [64];
    logic [31:0] mtg [64];
    logic [1:0]  mc  [64];

    m_branch_predictor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .lookup_pc   (lookup_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        prev_exp = '0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        logic [5:0] i;
        logic [7:0] t;
        i = pc[7:2];
        t = pc[15:8];
        if (mv[i] && mt[i] == t) begin
            if (tk) begin
                mc[i]  = (mc[i] == 2'b11) ? 2'b11 : mc[i] + 2'b01;
                mtg[i] = tg;
            end else begin
                mc[i] = (mc[i] == 2'b00) ? 2'b00 : mc[i] - 2'b01;
            end
        end else if (tk) begin
            mv[i]  = 1'b1;
            mt[i]  = t;
            mtg[i] = tg;
            mc[i]  = 2'b10;
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output exp_t e);
        logic [5:0] i;
        i = pc[7:2];
        e.hit    = mv[i] && (mt[i] == pc[15:8]);
        e.taken  = e.hit && mc[i][1];
        e.target = e.taken ? mtg[i] : pc + 32'd4;
    endtask

    // Drive one cycle, queue the model's expectation, compare one edge later.
    task automatic step(input string nm, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                        input logic c);
        exp_t e;
        exp_t got;
        @(negedge clk);
        lookup_pc  = lpc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        ce         = c;
        if (c) begin
`ifdef BPRED_BYPASS_EN
            if (uv) model_update(upc, ut, utg);
            model_lookup(lpc, e);
`else
            model_lookup(lpc, e);
            if (uv) model_update(upc, ut, utg);
`endif
            prev_exp = e;
        end else begin
            e = prev_exp;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val({nm, "_hit"},    {31'd0, pred_hit},   {31'd0, got.hit});
        check_val({nm, "_taken"},  {31'd0, pred_taken}, {31'd0, got.taken});
        check_val({nm, "_target"}, pred_target,         got.target);
    endtask

    task automatic lk(input string nm, input logic [31:0] pc);
        step(nm, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    endtask

    task automatic up(input string nm, input logic [31:0] lpc, input logic [31:0] upc,
                      input logic tk, input logic [31:0] tg);
        step(nm, lpc, 1'b1, upc, tk, tg, 1'b1);
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0:       r = 32'h0000_0048;
            1:       r = 32'h0000_0148;
            2:       r = 32'h0000_1000;
            3:       r = 32'h0000_004C;
            4:       r = 32'hFFFF_FFFC;
            default: r = {$urandom_range(0, 3), $urandom_range(0, 255), 2'b00} & 32'h0000_3FFC;
        endcase
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; ce = 1'b0; lookup_pc = 32'd0;
        upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0; upd_target = 32'd0;
        model_clear();
        #1;
        check_val("rst_hit",    {31'd0, pred_hit},   32'd0);
        check_val("rst_taken",  {31'd0, pred_taken}, 32'd0);
        check_val("rst_target", pred_target,         32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold lookup misses with fall-through target.
        lk("cold", 32'h48);
        check_val("cold_const_target", pred_target, 32'h4C);

        // Allocate, then hit.
        up("alloc", 32'h0, 32'h48, 1'b1, 32'h20);
        lk("hit1", 32'h48);
        check_val("hit1_const_hit",    {31'd0, pred_hit},   32'd1);
        check_val("hit1_const_target", pred_target,         32'h20);

        // Saturate low.
        for (int i = 0; i < 3; i++) up("nt", 32'h1000, 32'h48, 1'b0, 32'h0);
        lk("sat_lo", 32'h48);
        check_val("sat_lo_const_taken",  {31'd0, pred_taken}, 32'd0);
        check_val("sat_lo_const_target", pred_target,         32'h4C);

        // Saturate high, then two not-taken steps back down.
        for (int i = 0; i < 5; i++) up("tk", 32'h1000, 32'h48, 1'b1, 32'h20);
        up("nt1", 32'h1000, 32'h48, 1'b0, 32'h0);
        lk("sat_hi", 32'h48);
        check_val("sat_hi_const_taken", {31'd0, pred_taken}, 32'd1);
        up("nt2", 32'h1000, 32'h48, 1'b0, 32'h0);
        lk("sat_hi2", 32'h48);
        check_val("sat_hi2_const_taken", {31'd0, pred_taken}, 32'd0);

        // Alias replacement at index 18.
        up("alias", 32'h1000, 32'h148, 1'b1, 32'h300);
        lk("alias_old", 32'h48);
        check_val("alias_old_const_hit", {31'd0, pred_hit}, 32'd0);
        lk("alias_new", 32'h148);
        check_val("alias_new_const_target", pred_target, 32'h300);
        up("alias_nt", 32'h1000, 32'h148, 1'b0, 32'h0);
        lk("alias_ctr", 32'h148);
        check_val("alias_ctr_const_taken", {31'd0, pred_taken}, 32'd0);

        // Same-edge lookup and allocating update.
        up("same_edge", 32'h48, 32'h48, 1'b1, 32'h80);
`ifdef BPRED_BYPASS_EN
        check_val("same_edge_const_hit",    {31'd0, pred_hit}, 32'd1);
        check_val("same_edge_const_target", pred_target,       32'h80);
`else
        check_val("same_edge_const_hit",    {31'd0, pred_hit}, 32'd0);
`endif
        lk("post_edge", 32'h48);
        check_val("post_edge_const_target", pred_target, 32'h80);

        // Clock enable low: outputs hold, update dropped.
        step("ce_off", 32'h4000, 1'b1, 32'h200, 1'b1, 32'h44, 1'b0);
        check_val("ce_off_const_hit",    {31'd0, pred_hit}, 32'd1);
        check_val("ce_off_const_target", pred_target,       32'h80);
        lk("ce_on", 32'h200);
        check_val("ce_on_const_hit",    {31'd0, pred_hit}, 32'd0);
        check_val("ce_on_const_target", pred_target,       32'h204);

        // PC+4 wraps.
        lk("wrap", 32'hFFFF_FFFC);
        check_val("wrap_const_target", pred_target, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            step("rnd", pick_pc(), 1'($urandom_range(0, 1)), pick_pc(),
                 1'($urandom_range(0, 1)), {$urandom_range(0, 65535), 2'b00} & 32'h0003_FFFC,
                 1'($urandom_range(0, 9) != 0));
        end

        // Train a few entries, then reset mid-stream with an update pending.
        up("pre_rst", 32'h0, 32'h48, 1'b1, 32'h500);
        up("pre_rst2", 32'h0, 32'h1000, 1'b1, 32'h600);
        @(negedge clk);
        lookup_pc = 32'h48; upd_valid = 1'b1; upd_pc = 32'h148;
        upd_taken = 1'b1; upd_target = 32'h99; ce = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst_hit",    {31'd0, pred_hit},   32'd0);
        check_val("midrst_taken",  {31'd0, pred_taken}, 32'd0);
        check_val("midrst_target", pred_target,         32'd0);
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        model_clear();
        lk("after_rst_a", 32'h48);
        check_val("after_rst_a_const_hit", {31'd0, pred_hit}, 32'd0);
        lk("after_rst_b", 32'h148);
        check_val("after_rst_b_const_hit", {31'd0, pred_hit}, 32'd0);
        lk("after_rst_c", 32'h1000);
        check_val("after_rst_c_const_hit", {31'd0, pred_hit}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
